// File: rtl/dds_wave_gen_if.sv
// Config handshake, sine ROM port and DAC-side sample bus of dds_wave_gen.
interface dds_wave_gen_if #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [PHASE_W-1:0] cfg_ftw;
  logic [ADDR_W-1:0]  cfg_pow;
  logic [1:0]         cfg_wave;
  logic [DATA_W-1:0]  cfg_amp;
  logic [ADDR_W-1:0]  rom_addr;
  logic [DATA_W-1:0]  rom_data;
  logic               sample_valid;
  logic [DATA_W-1:0]  sample_data;

  // Config source, ROM and DAC stage side
  modport master (
    output cfg_valid, cfg_ftw, cfg_pow, cfg_wave, cfg_amp, rom_data,
    input  cfg_ready, rom_addr, sample_valid, sample_data
  );

  // Generator side
  modport slave (
    input  cfg_valid, cfg_ftw, cfg_pow, cfg_wave, cfg_amp, rom_data,
    output cfg_ready, rom_addr, sample_valid, sample_data
  );
endinterface

// File: rtl/dds_wave_gen.sv
// DDS sample source: phase accumulator, sine ROM addressing, waveform select
// and amplitude scaling about midscale, feeding the DAC stage every clk.
// Optional phase dithering is compiled in with `define DDS_DITHER_EN.
module dds_wave_gen #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  dds_wave_gen_if.slave bus
);

  localparam int unsigned CFG_W  = PHASE_W + ADDR_W + 2 + DATA_W;
  localparam int unsigned MID    = 1 << (DATA_W - 1);
  localparam int unsigned PROD_W = 2 * DATA_W + 1;
  localparam logic [CFG_W-1:0] CFG_RST = {{PHASE_W{1'b0}}, {ADDR_W{1'b0}}, 2'd0, {DATA_W{1'b1}}};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2} state_t;

  state_t             state;
  logic [PHASE_W-1:0] phase;
  logic [CFG_W-1:0]   act_cfg;
  logic [CFG_W-1:0]   shd_cfg;

  logic [CFG_W-1:0]   cfg_in_c;
  logic [PHASE_W-1:0] act_ftw_c;
  logic [ADDR_W-1:0]  act_pow_c;
  logic [1:0]         act_wave_c;
  logic [DATA_W-1:0]  act_amp_c;
  logic               cfg_hs_c;
  logic [PHASE_W:0]   sum_c;
  logic [PHASE_W-1:0] phase_idx_c;

  assign cfg_in_c = {bus.cfg_ftw, bus.cfg_pow, bus.cfg_wave, bus.cfg_amp};
  assign {act_ftw_c, act_pow_c, act_wave_c, act_amp_c} = act_cfg;
  assign cfg_hs_c = bus.cfg_valid & bus.cfg_ready;
  assign sum_c    = {1'b0, phase} + {1'b0, act_ftw_c};

  // Control FSM: phase accumulation, config handshake and wrap-aligned update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      phase         <= '0;
      act_cfg       <= CFG_RST;
      shd_cfg       <= '0;
      bus.cfg_ready <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_hs_c) act_cfg <= cfg_in_c;
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
            phase <= '0;
            if (cfg_hs_c) act_cfg <= cfg_in_c;
          end else begin
            phase <= sum_c[PHASE_W-1:0];
            if (cfg_hs_c) begin
              shd_cfg       <= cfg_in_c;
              state         <= PEND;
              bus.cfg_ready <= 1'b0;
            end
          end
        end
        PEND: begin
          if (!en) begin
            state         <= IDLE;
            phase         <= '0;
            act_cfg       <= shd_cfg;
            bus.cfg_ready <= 1'b1;
          end else begin
            phase <= sum_c[PHASE_W-1:0];
            // Carry out marks the wrap: swap config so the next add uses the new ftw
            if (sum_c[PHASE_W]) begin
              act_cfg       <= shd_cfg;
              state         <= RUN;
              bus.cfg_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DDS_DITHER_EN
  localparam int unsigned DITH_W = ((PHASE_W - ADDR_W) > 16) ? 16 : (PHASE_W - ADDR_W);
  logic [15:0] lfsr;

  // Fibonacci LFSR (taps 16,14,13,11) that only runs while generating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else if (state != IDLE) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign phase_idx_c = phase + PHASE_W'(lfsr[DITH_W-1:0]);
`else
  assign phase_idx_c = phase;
`endif

  logic [ADDR_W-1:0]        idx_c, idx1, idx2;
  logic [1:0]               wave1, wave2;
  logic [DATA_W-1:0]        amp1, amp2, amp3;
  logic [DATA_W-1:0]        raw3;
  logic [2:0]               en_d;
  logic [DATA_W-1:0]        ph_c, raw_c, sample_c;
  logic signed [DATA_W:0]   s_c;
  logic signed [PROD_W-1:0] prod_c, shift_c;

  assign idx_c = ADDR_W'(phase_idx_c >> (PHASE_W - ADDR_W)) + act_pow_c;
  assign ph_c  = DATA_W'(idx2 >> (ADDR_W - DATA_W));

  // Waveform shaping from the S2 index / ROM data
  always_comb begin
    raw_c = bus.rom_data;
    case (wave2)
      2'd0:    raw_c = bus.rom_data;
      2'd1:    raw_c = ph_c[DATA_W-1] ? '1 : '0;
      2'd2:    raw_c = ph_c[DATA_W-1] ? ~{ph_c[DATA_W-2:0], 1'b0} : {ph_c[DATA_W-2:0], 1'b0};
      default: raw_c = ph_c;
    endcase
  end

  assign s_c      = $signed({1'b0, raw3}) - $signed((DATA_W + 1)'(MID));
  assign prod_c   = PROD_W'(s_c) * PROD_W'($signed({1'b0, amp3}));
  assign shift_c  = prod_c >>> DATA_W;
  assign sample_c = DATA_W'(shift_c + $signed(PROD_W'(MID)));

  // Four-stage sample pipeline; wave/amp travel with the index so no sample mixes configs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rom_addr     <= '0;
      idx1             <= '0;
      idx2             <= '0;
      wave1            <= '0;
      wave2            <= '0;
      amp1             <= '1;
      amp2             <= '1;
      amp3             <= '1;
      raw3             <= DATA_W'(MID);
      bus.sample_data  <= DATA_W'(MID);
      en_d             <= '0;
      bus.sample_valid <= 1'b0;
    end else begin
      bus.rom_addr     <= idx_c;
      idx1             <= idx_c;
      wave1            <= act_wave_c;
      amp1             <= act_amp_c;
      idx2             <= idx1;
      wave2            <= wave1;
      amp2             <= amp1;
      raw3             <= raw_c;
      amp3             <= amp2;
      bus.sample_data  <= sample_c;
      en_d             <= {en_d[1:0], en};
      bus.sample_valid <= en_d[2];
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen with a sample scoreboard.
module tb_dds_wave_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  dds_wave_gen_if #(.PHASE_W(32), .ADDR_W(8), .DATA_W(8)) bus ();

  dds_wave_gen #(.PHASE_W(32), .ADDR_W(8), .DATA_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic       sb_armed = 1'b0;
  int         sb_idx = 0;
  string      tag = "none";

  // Arbitrary but known "sine" table contents
  function automatic logic [7:0] rom_fn(input logic [7:0] a);
    return 8'(a * 8'd37 + 8'd11);
  endfunction

  // Synchronous ROM: data one clk after address
  always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

  // Amplitude scaling about midscale, in plain integer arithmetic
  function automatic logic [7:0] scale(input logic [7:0] raw, input logic [7:0] amp);
    int s;
    int p;
    s = int'(raw) - 128;
    p = s * int'(amp);
    return 8'(128 + (p >>> 8));
  endfunction

  function automatic logic [7:0] raw_fn(input logic [1:0] w, input logic [7:0] n);
    int v;
    v = int'(n);
    case (w)
      2'd0:    return rom_fn(n);
      2'd1:    return (v >= 128) ? 8'hFF : 8'h00;
      2'd2:    return (v < 128) ? 8'(2 * v) : 8'(255 - 2 * (v - 128));
      default: return n;
    endcase
  endfunction

  // Scoreboard: pop and compare each valid sample
  always @(negedge clk) begin
    if (sb_armed && bus.sample_valid && exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (bus.sample_data !== exp_v) begin
        errors++;
        $display("FAIL %s sample #%0d: got %h, expected %h", tag, sb_idx, bus.sample_data, exp_v);
      end
      sb_idx++;
    end
  end

  task automatic do_reset();
    en = 1'b0;
    bus.cfg_valid = 1'b0;
    sb_armed = 1'b0;
    exp_q.delete();
    sb_idx = 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cfg_idle(input logic [31:0] ftw, input logic [7:0] pow,
                          input logic [1:0] wave, input logic [7:0] amp);
    logic acc;
    acc = 1'b0;
    bus.cfg_valid = 1'b1;
    bus.cfg_ftw = ftw;
    bus.cfg_pow = pow;
    bus.cfg_wave = wave;
    bus.cfg_amp = amp;
    for (int k = 0; k < 8 && !acc; k++) begin
      acc = bus.cfg_ready;
      @(negedge clk);
    end
    bus.cfg_valid = 1'b0;
    checks++;
    if (acc !== 1'b1) begin
      errors++;
      $display("FAIL cfg_accept: cfg_ready never seen, got %b required 1", acc);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready: got %b required 1", bus.cfg_ready); end
    checks++;
    if (bus.rom_addr !== 8'h00) begin errors++; $display("FAIL rst_rom_addr: got %h required 00", bus.rom_addr); end
    checks++;
    if (bus.sample_data !== 8'h80) begin errors++; $display("FAIL rst_sample_data: got %h required 80", bus.sample_data); end
    checks++;
    if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL rst_sample_valid: got %b required 0", bus.sample_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.sample_data !== 8'h80) begin errors++; $display("FAIL rst_release_data: got %h required 80", bus.sample_data); end
  endtask

  task automatic test_sawtooth();
    logic [7:0] n;
    do_reset();
    cfg_idle(32'h0100_0000, 8'h00, 2'd3, 8'hFF);
    tag = "saw";
    for (int j = 0; j < 20; j++) begin
      n = (j == 0) ? 8'h00 : 8'(j - 1);
      exp_q.push_back(scale(raw_fn(2'd3, n), 8'hFF));
    end
    sb_armed = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n = (k == 0) ? 8'h00 : 8'(k - 1);
      checks++;
      if (bus.rom_addr !== n) begin errors++; $display("FAIL saw_rom_addr k=%0d: got %h required %h", k, bus.rom_addr, n); end
      checks++;
      if (bus.sample_valid !== 1'(k >= 3)) begin
        errors++;
        $display("FAIL saw_valid k=%0d: got %b required %b", k, bus.sample_valid, 1'(k >= 3));
      end
    end
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL saw_drain: %0d outstanding, required 0", exp_q.size()); end
    sb_armed = 1'b0;
  endtask

  task automatic test_sine();
    logic [7:0] n;
    do_reset();
    cfg_idle(32'h0200_0000, 8'h00, 2'd0, 8'h60);
    tag = "sine";
    for (int j = 0; j < 16; j++) begin
      n = (j == 0) ? 8'h00 : 8'(2 * (j - 1));
      exp_q.push_back(scale(raw_fn(2'd0, n), 8'h60));
    end
    sb_armed = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sine_drain: %0d outstanding, required 0", exp_q.size()); end
    sb_armed = 1'b0;
  endtask

  task automatic test_square();
    logic [7:0] n;
    logic [7:0] amps [2];
    amps = '{8'h00, 8'h80};
    for (int a = 0; a < 2; a++) begin
      do_reset();
      cfg_idle(32'h4000_0000, 8'h00, 2'd1, amps[a]);
      tag = (a == 0) ? "square_amp0" : "square_amp80";
      for (int j = 0; j < 10; j++) begin
        n = (j == 0) ? 8'h00 : 8'((j - 1) * 64);
        exp_q.push_back(scale(raw_fn(2'd1, n), amps[a]));
      end
      sb_armed = 1'b1;
      en = 1'b1;
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL %s_drain: %0d outstanding, required 0", tag, exp_q.size()); end
      sb_armed = 1'b0;
    end
  endtask

  task automatic test_triangle();
    logic [7:0] n;
    do_reset();
    cfg_idle(32'h0100_0000, 8'h40, 2'd2, 8'hFF);
    tag = "tri";
    for (int j = 0; j < 80; j++) begin
      n = 8'h40 + ((j == 0) ? 8'h00 : 8'(j - 1));
      exp_q.push_back(scale(raw_fn(2'd2, n), 8'hFF));
    end
    sb_armed = 1'b1;
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rom_addr !== 8'h40) begin errors++; $display("FAIL tri_first_addr: got %h required 40", bus.rom_addr); end
    for (int k = 0; k < 120 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL tri_drain: %0d outstanding, required 0", exp_q.size()); end
    sb_armed = 1'b0;
  endtask

  task automatic test_cfg_pend();
    logic [7:0] ea [9];
    logic       er [9];
    ea = '{8'h00, 8'h00, 8'h40, 8'h80, 8'hC0, 8'h00, 8'h80, 8'h00, 8'h80};
    er = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    cfg_idle(32'h4000_0000, 8'h00, 2'd3, 8'hFF);
    en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      checks++;
      if (bus.rom_addr !== ea[k]) begin errors++; $display("FAIL pend_addr k=%0d: got %h required %h", k, bus.rom_addr, ea[k]); end
      checks++;
      if (bus.cfg_ready !== er[k]) begin errors++; $display("FAIL pend_ready k=%0d: got %b required %b", k, bus.cfg_ready, er[k]); end
      if (k == 0) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_ftw = 32'h8000_0000;
      end else begin
        bus.cfg_valid = 1'b0;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_en_drop();
    logic [7:0] ea [10];
    logic       er [10];
    logic       ev [10];
    ea = '{8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h40};
    er = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    cfg_idle(32'h4000_0000, 8'h00, 2'd3, 8'hFF);
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (bus.rom_addr !== ea[k]) begin errors++; $display("FAIL drop_addr k=%0d: got %h required %h", k, bus.rom_addr, ea[k]); end
      checks++;
      if (bus.cfg_ready !== er[k]) begin errors++; $display("FAIL drop_ready k=%0d: got %b required %b", k, bus.cfg_ready, er[k]); end
      checks++;
      if (bus.sample_valid !== ev[k]) begin errors++; $display("FAIL drop_valid k=%0d: got %b required %b", k, bus.sample_valid, ev[k]); end
      if (k == 0) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_ftw = 32'h2000_0000;
      end else if (k == 1) begin
        bus.cfg_valid = 1'b0;
        en = 1'b0;
      end else if (k == 5) begin
        en = 1'b1;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_reset_pend();
    do_reset();
    cfg_idle(32'h1000_0000, 8'h00, 2'd3, 8'hFF);
    en = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.cfg_ftw = 32'h8000_0000;
    bus.cfg_pow = 8'h10;
    bus.cfg_wave = 2'd1;
    bus.cfg_amp = 8'h00;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    checks++;
    if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL rp_pend_ready: got %b required 0", bus.cfg_ready); end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.sample_valid !== 1'b1) begin errors++; $display("FAIL rp_valid_before: got %b required 1", bus.sample_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL rp_valid_async: got %b required 0", bus.sample_valid); end
    checks++;
    if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL rp_ready_async: got %b required 1", bus.cfg_ready); end
    checks++;
    if (bus.sample_data !== 8'h80) begin errors++; $display("FAIL rp_data_async: got %h required 80", bus.sample_data); end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tag = "rst_defaults";
    sb_idx = 0;
    exp_q.delete();
    for (int j = 0; j < 8; j++) exp_q.push_back(scale(rom_fn(8'h00), 8'hFF));
    sb_armed = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.rom_addr !== 8'h00) begin errors++; $display("FAIL rp_default_addr k=%0d: got %h required 00", k, bus.rom_addr); end
    end
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rp_drain: %0d outstanding, required 0", exp_q.size()); end
    sb_armed = 1'b0;
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    en = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_ftw = '0;
    bus.cfg_pow = '0;
    bus.cfg_wave = '0;
    bus.cfg_amp = '0;
    test_reset();
    test_sawtooth();
    test_sine();
    test_square();
    test_triangle();
    test_cfg_pend();
    test_en_drop();
    test_reset_pend();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
